// File: rtl/cache_line_sequencer_pkg.sv
// cache_line_sequencer_pkg
//   Shared types for the cache line sequencer slice.
//   data_word_t       : one 32-bit data array word
//   line_seq_state_t  : sequencer FSM state encoding (IDLE, REFILL, WB_READ,
//                       WB_LOAD, WB_SEND, DONE)
package cache_line_sequencer_pkg;

    typedef logic [31:0] data_word_t;

    typedef enum logic [2:0] {
        LS_IDLE    = 3'd0,
        LS_REFILL  = 3'd1,
        LS_WB_READ = 3'd2,
        LS_WB_LOAD = 3'd3,
        LS_WB_SEND = 3'd4,
        LS_DONE    = 3'd5
    } line_seq_state_t;

endpackage

// File: rtl/cache_line_sequencer_if.sv
// cache_line_sequencer_if
//   Memory-side line streams of the sequencer: refill words coming in from
//   memory and writeback words going out to memory, each with valid/ready.
//   refill_valid/refill_data  : memory -> sequencer refill word
//   refill_ready              : sequencer -> memory, accepts refill word
//   wb_valid/wb_data/wb_last  : sequencer -> memory writeback word
//   wb_ready                  : memory -> sequencer, accepts writeback word
//   master modport = sequencer side, slave modport = memory side.
interface cache_line_sequencer_if;
    import cache_line_sequencer_pkg::*;

    logic       refill_valid;
    data_word_t refill_data;
    logic       refill_ready;
    logic       wb_valid;
    data_word_t wb_data;
    logic       wb_last;
    logic       wb_ready;

    modport master (
        input  refill_valid,
        input  refill_data,
        output refill_ready,
        output wb_valid,
        output wb_data,
        output wb_last,
        input  wb_ready
    );

    modport slave (
        output refill_valid,
        output refill_data,
        input  refill_ready,
        input  wb_valid,
        input  wb_data,
        input  wb_last,
        output wb_ready
    );

endinterface

// File: rtl/cache_line_sequencer.sv
// cache_line_sequencer
//   Arbitrates one banked data array between single-word CPU load/store
//   accesses and whole-line refill/writeback operations.
//   clk_i, rst_i           : clock, async active-high reset
//   cpu_*                  : CPU single-word request, grant and read-valid
//   refill_start_i,
//   writeback_start_i,
//   line_address_i         : line operation start from the cache FSM
//   mem_if (master)        : refill / writeback word streams to memory
//   busy_o, done_o         : line operation status
//   block_*                : data array write/read ports and read data
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | CPU may access the array; waits for a line start
//   REFILL   | writes one refill word per handshake, banks 0..N-1
//   WB_READ  | issues the array read for the current bank
//   WB_LOAD  | captures the array read data into the writeback register
//   WB_SEND  | offers the word to memory until wb_ready
//   DONE     | one-cycle completion pulse, then IDLE
module cache_line_sequencer
    import cache_line_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int BANK_ADDRESS = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    cpu_read_i,
    input  logic                    cpu_write_i,
    input  logic [ADDR_WIDTH-1:0]   cpu_address_i,
    input  logic [BANK_ADDRESS-1:0] cpu_bank_i,
    input  logic [3:0]              cpu_byte_write_i,
    input  data_word_t              cpu_data_i,
    output logic                    cpu_grant_o,
    output logic                    cpu_read_valid_o,

    input  logic                    refill_start_i,
    input  logic                    writeback_start_i,
    input  logic [ADDR_WIDTH-1:0]   line_address_i,

    cache_line_sequencer_if.master  mem_if,

    output logic                    busy_o,
    output logic                    done_o,

    output logic                    block_write_o,
    output logic [BANK_ADDRESS-1:0] block_write_bank_o,
    output logic [ADDR_WIDTH-1:0]   block_write_address_o,
    output logic [3:0]              block_byte_write_o,
    output data_word_t              block_write_data_o,
    output logic                    block_read_o,
    output logic [BANK_ADDRESS-1:0] block_read_bank_o,
    output logic [ADDR_WIDTH-1:0]   block_read_address_o,
    input  data_word_t              block_read_data_i
);

    localparam int BANK_NUMBER = 2 ** BANK_ADDRESS;
    localparam logic [BANK_ADDRESS-1:0] LAST_BANK = BANK_ADDRESS'(BANK_NUMBER - 1);

    localparam logic [2:0] ST_IDLE    = LS_IDLE;
    localparam logic [2:0] ST_REFILL  = LS_REFILL;
    localparam logic [2:0] ST_WB_READ = LS_WB_READ;
    localparam logic [2:0] ST_WB_LOAD = LS_WB_LOAD;
    localparam logic [2:0] ST_WB_SEND = LS_WB_SEND;
    localparam logic [2:0] ST_DONE    = LS_DONE;

    logic [2:0]              state_q;
    logic [2:0]              state_d;
    logic [BANK_ADDRESS-1:0] count_q;
    logic [ADDR_WIDTH-1:0]   line_q;
    data_word_t              wb_data_q;
    logic                    last_word;
    logic                    refill_fire;

    assign last_word   = (count_q == LAST_BANK);
    assign refill_fire = (state_q == ST_REFILL) && mem_if.refill_valid;

    assign mem_if.wb_data = wb_data_q;

    always_comb begin
        cpu_grant_o           = 1'b0;
        mem_if.refill_ready   = 1'b0;
        mem_if.wb_valid       = 1'b0;
        mem_if.wb_last        = 1'b0;
        busy_o                = 1'b0;
        done_o                = 1'b0;
        block_write_o         = 1'b0;
        block_write_bank_o    = '0;
        block_write_address_o = '0;
        block_byte_write_o    = 4'b0000;
        block_write_data_o    = '0;
        block_read_o          = 1'b0;
        block_read_bank_o     = '0;
        block_read_address_o  = '0;
        state_d               = state_q;

        case (state_q)
            ST_IDLE: begin
                // Grant is also held off while reset is asserted so the array
                // ports stay quiet during reset.
                cpu_grant_o = !rst_i && !refill_start_i && !writeback_start_i;
                if (cpu_grant_o) begin
                    block_write_o         = cpu_write_i;
                    block_write_bank_o    = cpu_bank_i;
                    block_write_address_o = cpu_address_i;
                    block_byte_write_o    = cpu_byte_write_i;
                    block_write_data_o    = cpu_data_i;
                    block_read_o          = cpu_read_i;
                    block_read_bank_o     = cpu_bank_i;
                    block_read_address_o  = cpu_address_i;
                end
                // Writeback wins; a refill started in the same cycle is dropped.
                if (writeback_start_i) begin
                    state_d = ST_WB_READ;
                end else if (refill_start_i) begin
                    state_d = ST_REFILL;
                end
            end
            ST_REFILL: begin
                busy_o              = 1'b1;
                mem_if.refill_ready = 1'b1;
                if (mem_if.refill_valid) begin
                    block_write_o         = 1'b1;
                    block_write_bank_o    = count_q;
                    block_write_address_o = line_q;
                    block_byte_write_o    = 4'b1111;
                    block_write_data_o    = mem_if.refill_data;
                    if (last_word) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_WB_READ: begin
                busy_o               = 1'b1;
                block_read_o         = 1'b1;
                block_read_bank_o    = count_q;
                block_read_address_o = line_q;
                state_d              = ST_WB_LOAD;
            end
            ST_WB_LOAD: begin
                busy_o  = 1'b1;
                state_d = ST_WB_SEND;
            end
            ST_WB_SEND: begin
                busy_o          = 1'b1;
                mem_if.wb_valid = 1'b1;
                mem_if.wb_last  = last_word;
                if (mem_if.wb_ready) begin
                    state_d = last_word ? ST_DONE : ST_WB_READ;
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q          <= ST_IDLE;
            count_q          <= '0;
            line_q           <= '0;
            wb_data_q        <= '0;
            cpu_read_valid_o <= 1'b0;
        end else begin
            state_q          <= state_d;
            cpu_read_valid_o <= cpu_grant_o && cpu_read_i;

            if (state_q == ST_IDLE && (writeback_start_i || refill_start_i)) begin
                line_q  <= line_address_i;
                count_q <= '0;
            end

            // Counter wraps to 0 after the last word; nothing reads it then.
            if (refill_fire) begin
                count_q <= count_q + BANK_ADDRESS'(1);
            end

            if (state_q == ST_WB_LOAD) begin
                wb_data_q <= block_read_data_i;
            end

            if (state_q == ST_WB_SEND && mem_if.wb_ready && !last_word) begin
                count_q <= count_q + BANK_ADDRESS'(1);
            end
        end
    end

endmodule

// File: tb/tb_cache_line_sequencer.sv
// tb_cache_line_sequencer
//   Directed bench for cache_line_sequencer (ADDR_WIDTH=8, BANK_ADDRESS=2)
//   with a small behavioural data array (1-cycle read latency, byte write).
//   Inputs change just after the falling edge; outputs are compared 1 time
//   unit later, well away from the rising edge.
module tb_cache_line_sequencer;
    import cache_line_sequencer_pkg::*;

    localparam int AW = 8;
    localparam int BA = 2;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cpu_read_i, cpu_write_i;
    logic [AW-1:0] cpu_address_i;
    logic [BA-1:0] cpu_bank_i;
    logic [3:0]    cpu_byte_write_i;
    data_word_t    cpu_data_i;
    logic          cpu_grant_o, cpu_read_valid_o;
    logic          refill_start_i, writeback_start_i;
    logic [AW-1:0] line_address_i;
    logic          busy_o, done_o;
    logic          block_write_o;
    logic [BA-1:0] block_write_bank_o;
    logic [AW-1:0] block_write_address_o;
    logic [3:0]    block_byte_write_o;
    data_word_t    block_write_data_o;
    logic          block_read_o;
    logic [BA-1:0] block_read_bank_o;
    logic [AW-1:0] block_read_address_o;
    data_word_t    block_read_data_i;

    int n_checks = 0;
    int n_fail   = 0;

    cache_line_sequencer_if mem_if ();

    cache_line_sequencer #(.ADDR_WIDTH(AW), .BANK_ADDRESS(BA)) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .cpu_read_i            (cpu_read_i),
        .cpu_write_i           (cpu_write_i),
        .cpu_address_i         (cpu_address_i),
        .cpu_bank_i            (cpu_bank_i),
        .cpu_byte_write_i      (cpu_byte_write_i),
        .cpu_data_i            (cpu_data_i),
        .cpu_grant_o           (cpu_grant_o),
        .cpu_read_valid_o      (cpu_read_valid_o),
        .refill_start_i        (refill_start_i),
        .writeback_start_i     (writeback_start_i),
        .line_address_i        (line_address_i),
        .mem_if                (mem_if.master),
        .busy_o                (busy_o),
        .done_o                (done_o),
        .block_write_o         (block_write_o),
        .block_write_bank_o    (block_write_bank_o),
        .block_write_address_o (block_write_address_o),
        .block_byte_write_o    (block_byte_write_o),
        .block_write_data_o    (block_write_data_o),
        .block_read_o          (block_read_o),
        .block_read_bank_o     (block_read_bank_o),
        .block_read_address_o  (block_read_address_o),
        .block_read_data_i     (block_read_data_i)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural data array.
    logic [31:0] mem [0:255][0:3];
    always @(posedge clk_i) begin
        if (block_write_o) begin
            for (int b = 0; b < 4; b++) begin
                if (block_byte_write_o[b]) begin
                    mem[block_write_address_o][block_write_bank_o][8*b +: 8] <= block_write_data_o[8*b +: 8];
                end
            end
        end
        if (block_read_o) begin
            block_read_data_i <= mem[block_read_address_o][block_read_bank_o];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk_i);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " grant"},       32'(cpu_grant_o), 32'd0);
        chk({tag, " read_valid"},  32'(cpu_read_valid_o), 32'd0);
        chk({tag, " busy"},        32'(busy_o), 32'd0);
        chk({tag, " done"},        32'(done_o), 32'd0);
        chk({tag, " refill_rdy"},  32'(mem_if.refill_ready), 32'd0);
        chk({tag, " wb_valid"},    32'(mem_if.wb_valid), 32'd0);
        chk({tag, " wb_data"},     mem_if.wb_data, 32'd0);
        chk({tag, " wb_last"},     32'(mem_if.wb_last), 32'd0);
        chk({tag, " blk_write"},   32'(block_write_o), 32'd0);
        chk({tag, " blk_read"},    32'(block_read_o), 32'd0);
    endtask

    initial begin
        rst_i = 1'b1;
        cpu_read_i = 0; cpu_write_i = 0; cpu_address_i = '0; cpu_bank_i = '0;
        cpu_byte_write_i = '0; cpu_data_i = '0;
        refill_start_i = 0; writeback_start_i = 0; line_address_i = '0;
        mem_if.refill_valid = 0; mem_if.refill_data = '0; mem_if.wb_ready = 0;

        // Reset state
        nxt(); #1;
        chk_all_zero("reset");
        nxt(); rst_i = 1'b0; #1;
        chk("idle grant", 32'(cpu_grant_o), 32'd1);

        // Refill line 0x05 with A0..A3, valid held high
        nxt(); refill_start_i = 1; line_address_i = 8'h05; #1;
        chk("refill start grant", 32'(cpu_grant_o), 32'd0);
        chk("refill start busy", 32'(busy_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            nxt(); refill_start_i = 0; mem_if.refill_valid = 1; mem_if.refill_data = 32'hA0 + i; #1;
            chk("refill ready", 32'(mem_if.refill_ready), 32'd1);
            chk("refill busy", 32'(busy_o), 32'd1);
            chk("refill write", 32'(block_write_o), 32'd1);
            chk("refill bank", 32'(block_write_bank_o), 32'(i));
            chk("refill addr", 32'(block_write_address_o), 32'h05);
            chk("refill be", 32'(block_byte_write_o), 32'hF);
            chk("refill data", block_write_data_o, 32'hA0 + i);
            chk("refill done early", 32'(done_o), 32'd0);
        end
        nxt(); mem_if.refill_valid = 0; #1;
        chk("refill done", 32'(done_o), 32'd1);
        chk("refill done busy", 32'(busy_o), 32'd0);
        chk("refill done grant", 32'(cpu_grant_o), 32'd0);
        chk("refill done write", 32'(block_write_o), 32'd0);
        nxt(); #1;
        chk("refill done cleared", 32'(done_o), 32'd0);

        // CPU reads of line 0x05 banks 0..3
        for (int i = 0; i < 5; i++) begin
            nxt(); cpu_read_i = (i < 4); cpu_bank_i = BA'(i); cpu_address_i = 8'h05; #1;
            if (i == 0) begin
                chk("rd valid first", 32'(cpu_read_valid_o), 32'd0);
            end else begin
                chk("rd valid", 32'(cpu_read_valid_o), 32'd1);
                chk("rd data", block_read_data_i, 32'hA0 + i - 1);
            end
            if (i < 4) begin
                chk("rd grant", 32'(cpu_grant_o), 32'd1);
                chk("rd port", 32'(block_read_o), 32'd1);
            end
        end
        nxt(); #1;
        chk("rd valid idle", 32'(cpu_read_valid_o), 32'd0);

        // Writeback line 0x05 with a 2-cycle stall on word 1
        nxt(); writeback_start_i = 1; line_address_i = 8'h05; #1;
        chk("wb start grant", 32'(cpu_grant_o), 32'd0);
        for (int k = 0; k < 4; k++) begin
            nxt(); writeback_start_i = 0; mem_if.wb_ready = 0; #1;
            chk("wb read", 32'(block_read_o), 32'd1);
            chk("wb read bank", 32'(block_read_bank_o), 32'(k));
            chk("wb read addr", 32'(block_read_address_o), 32'h05);
            chk("wb read valid", 32'(mem_if.wb_valid), 32'd0);
            chk("wb busy", 32'(busy_o), 32'd1);
            nxt(); #1;
            chk("wb load read", 32'(block_read_o), 32'd0);
            chk("wb load valid", 32'(mem_if.wb_valid), 32'd0);
            for (int s = 0; s < ((k == 1) ? 2 : 0); s++) begin
                nxt(); mem_if.wb_ready = 0; #1;
                chk("wb stall valid", 32'(mem_if.wb_valid), 32'd1);
                chk("wb stall data", mem_if.wb_data, 32'hA0 + k);
                chk("wb stall last", 32'(mem_if.wb_last), 32'd0);
            end
            nxt(); mem_if.wb_ready = 1; #1;
            chk("wb valid", 32'(mem_if.wb_valid), 32'd1);
            chk("wb data", mem_if.wb_data, 32'hA0 + k);
            chk("wb last", 32'(mem_if.wb_last), 32'(k == 3));
            chk("wb done early", 32'(done_o), 32'd0);
        end
        nxt(); mem_if.wb_ready = 0; #1;
        chk("wb done", 32'(done_o), 32'd1);
        chk("wb done valid", 32'(mem_if.wb_valid), 32'd0);
        chk("wb done busy", 32'(busy_o), 32'd0);
        nxt(); #1;
        chk("wb done cleared", 32'(done_o), 32'd0);

        // Simultaneous starts: writeback wins, refill dropped
        nxt(); writeback_start_i = 1; refill_start_i = 1; line_address_i = 8'h05;
        mem_if.refill_valid = 1; mem_if.refill_data = 32'h55; mem_if.wb_ready = 1; #1;
        chk("both grant", 32'(cpu_grant_o), 32'd0);
        chk("both write", 32'(block_write_o), 32'd0);
        for (int c = 0; c <= 12; c++) begin
            nxt(); writeback_start_i = 0; refill_start_i = 0; #1;
            chk("both no write", 32'(block_write_o), 32'd0);
            chk("both refill rdy", 32'(mem_if.refill_ready), 32'd0);
            chk("both done", 32'(done_o), 32'(c == 12));
            chk("both busy", 32'(busy_o), 32'(c < 12));
        end
        nxt(); mem_if.refill_valid = 0; mem_if.wb_ready = 0; #1;
        chk("both idle refill rdy", 32'(mem_if.refill_ready), 32'd0);
        chk("both idle busy", 32'(busy_o), 32'd0);

        // Refill line 0x07 (B0..B3) with a CPU write held from word 2
        nxt(); refill_start_i = 1; line_address_i = 8'h07; #1;
        for (int i = 0; i < 4; i++) begin
            nxt(); refill_start_i = 0; mem_if.refill_valid = 1; mem_if.refill_data = 32'hB0 + i;
            if (i == 2) begin
                cpu_write_i = 1; cpu_address_i = 8'h07; cpu_bank_i = 2'd1;
                cpu_byte_write_i = 4'b1000; cpu_data_i = 32'hDEADBEEF;
            end
            #1;
            chk("cpu-refill bank", 32'(block_write_bank_o), 32'(i));
            chk("cpu-refill data", block_write_data_o, 32'hB0 + i);
            if (i >= 2) chk("cpu-refill grant", 32'(cpu_grant_o), 32'd0);
        end
        nxt(); mem_if.refill_valid = 0; #1;
        chk("cpu-refill done", 32'(done_o), 32'd1);
        chk("cpu-refill done grant", 32'(cpu_grant_o), 32'd0);
        chk("cpu-refill done write", 32'(block_write_o), 32'd0);
        nxt(); #1;
        chk("cpu-refill grant", 32'(cpu_grant_o), 32'd1);
        chk("cpu-refill cpu write", 32'(block_write_o), 32'd1);
        chk("cpu-refill cpu bank", 32'(block_write_bank_o), 32'd1);
        chk("cpu-refill cpu addr", 32'(block_write_address_o), 32'h07);
        chk("cpu-refill cpu be", 32'(block_byte_write_o), 32'h8);
        chk("cpu-refill cpu data", block_write_data_o, 32'hDEADBEEF);
        nxt(); cpu_write_i = 0; cpu_read_i = 1; #1;
        chk("cpu-refill rd grant", 32'(cpu_grant_o), 32'd1);
        nxt(); cpu_read_i = 0; #1;
        chk("cpu-refill rd valid", 32'(cpu_read_valid_o), 32'd1);
        chk("cpu-refill rd data", block_read_data_i, 32'hDE0000B1);

        // CPU byte write to line 0x05 bank 2, then read back
        nxt(); cpu_write_i = 1; cpu_address_i = 8'h05; cpu_bank_i = 2'd2;
        cpu_byte_write_i = 4'b0011; cpu_data_i = 32'h11223344; #1;
        chk("bw grant", 32'(cpu_grant_o), 32'd1);
        chk("bw write", 32'(block_write_o), 32'd1);
        chk("bw be", 32'(block_byte_write_o), 32'h3);
        nxt(); cpu_write_i = 0; cpu_read_i = 1; #1;
        chk("bw rd valid early", 32'(cpu_read_valid_o), 32'd0);
        nxt(); cpu_read_i = 0; #1;
        chk("bw rd valid", 32'(cpu_read_valid_o), 32'd1);
        chk("bw rd data", block_read_data_i, 32'h00003344);
        nxt(); #1;
        chk("bw rd valid drop", 32'(cpu_read_valid_o), 32'd0);

        // Reset during WB_SEND
        nxt(); writeback_start_i = 1; line_address_i = 8'h07; mem_if.wb_ready = 0;
        nxt(); writeback_start_i = 0;
        nxt();
        nxt(); #1;
        chk("rstwb valid", 32'(mem_if.wb_valid), 32'd1);
        chk("rstwb data", mem_if.wb_data, 32'hB0);
        nxt(); rst_i = 1; mem_if.wb_ready = 1; #1;
        chk_all_zero("rstwb");
        nxt(); #1;
        chk("rstwb hold done", 32'(done_o), 32'd0);
        chk("rstwb hold busy", 32'(busy_o), 32'd0);
        nxt(); rst_i = 0; mem_if.wb_ready = 0; #1;
        chk("rstwb idle busy", 32'(busy_o), 32'd0);
        chk("rstwb idle done", 32'(done_o), 32'd0);
        chk("rstwb idle grant", 32'(cpu_grant_o), 32'd1);
        chk("rstwb idle valid", 32'(mem_if.wb_valid), 32'd0);
        chk("rstwb idle data", mem_if.wb_data, 32'd0);
        nxt(); #1;
        chk("rstwb after done", 32'(done_o), 32'd0);
        chk("rstwb after busy", 32'(busy_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
